if_id_stage: RTL and testbench
==============================

# if_id_stage

Instruction-fetch stage and IF/ID pipeline register for the five-stage RV32I core. Holds the PC, drives the instruction-memory address, latches fetched words into the IF/ID register, and applies stall and redirect requests. Sits directly upstream of the ID-stage decoder and feeds it `id_instr` and the `flush` kill signal. Also provides `id_pc` and `id_pc_plus4` for branch-target and link computation.

## Interface

- `PC_RESET`, 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0013: instruction (`addi x0,x0,0`) inserted into IF/ID for bubbles.

- `clk`  in  1: rising-edge clock; the single clock of the block.
- `Reset`  in  1: asynchronous, active-high reset.
- `stall`  in  1: load-use hold request from the hazard unit.
- `redirect`  in  1: taken branch, jal or jalr resolved in EX.
- `redirect_pc`  in  32: target address for the redirect.
- `imem_addr`  out  32: instruction-memory address; equals `pc`.
- `imem_rdata`  in  32: instruction word; combinational read of `imem_addr`.
- `id_instr`  out  32: IF/ID instruction register.
- `id_pc`  out  32: PC of `id_instr`.
- `id_pc_plus4`  out  32: `id_pc + 4`, modulo 2^32, combinational.
- `id_valid`  out  1: IF/ID holds a real fetched instruction.
- `flush`  out  1: kill the instruction currently in ID; combinational, equals `redirect | ~id_valid`.
- `misalign`  out  1: sticky flag; set when a redirect target has `redirect_pc[1:0] != 0`.
- `fetch_count`  out  32: count of instructions accepted into IF/ID; saturating.

## Operation

- **State:** `pc`, `id_instr`, `id_pc`, `id_valid`, `misalign`, `fetch_count`. All are updated on the rising edge of `clk`.
- **Reset values (asynchronous, while `Reset` = 1):**
  - `pc = PC_RESET`, `id_instr = NOP_INSTR`, `id_pc = 0`
  - `id_valid = 0`, `misalign = 0`, `fetch_count = 0`
  - Resulting outputs: `flush = 1`, `imem_addr = PC_RESET`.
- **Per-cycle priority:** `redirect` > `stall` > normal advance.
- **Redirect:**
  - `pc <= {redirect_pc[31:2], 2'b00}`.
  - `id_instr <= NOP_INSTR`, `id_pc <= 0`, `id_valid <= 0`.
  - `fetch_count` holds.
  - If `redirect_pc[1:0] != 0`, then `misalign <= 1`.
- **Stall (no redirect):** `pc`, `id_instr`, `id_pc`, `id_valid` and `fetch_count` all hold. `imem_addr` stays stable.
- **Normal advance:**
  - `pc <= pc + 4`, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
  - `id_instr <= imem_rdata`, `id_pc <= pc`, `id_valid <= 1`.
  - `fetch_count <= fetch_count + 1`, saturating at 32'hFFFF_FFFF.
- **Flush:** `flush` is asserted in the same cycle `redirect` is high, killing the wrong-path instruction in ID. On the following cycle it is asserted again because the bubble has `id_valid = 0`. The decoder zeroes all control for any cycle with `flush = 1`.
- **Misalign:** stays set once set; only `Reset` clears it. Fetch continues from the aligned address.
- **Stall with `id_valid = 0`:** the bubble is held, and `flush` stays 1 for the whole stall.
- **Reset mid-operation:** the asynchronous assert immediately forces all reset values, regardless of any `stall` or `redirect` in progress. First fetch is at `PC_RESET` on the first rising edge after `Reset` deasserts.

## Timing

- **Fetch latency:** the word at `pc` in cycle t appears on `id_instr` in cycle t+1 (one register stage).
- **Redirect penalty:** with `redirect` high in cycle t:
  - cycle t+1: `pc = target`, IF/ID holds a bubble.
  - cycle t+2: `id_instr = mem[target]`.
  - Two cycles are lost, both flagged by `flush`.
- **Stall:** each stall cycle adds exactly one cycle. Fetch resumes on the first edge with `stall = 0`, with no lost or duplicated instruction.
- **Combinational paths:** `flush`, `imem_addr` and `id_pc_plus4` have no clock-to-output register beyond their source flops. `flush` has a combinational path from `redirect`.
- **Simultaneous `stall` and `redirect`:** the redirect is taken. The stall is dropped for that cycle.

## Test plan

- **Reset then run:** assert `Reset` for 2 cycles, release, memory holds sequential addi words.
  - During reset: `id_valid = 0`, `flush = 1`.
  - After release: `imem_addr` = 0, 4, 8, … on successive cycles; `id_pc` lags by one cycle; `fetch_count` = 3 after 3 cycles.
- **Stall:** at `pc` = 0x10, assert `stall` for 2 cycles.
  - `imem_addr` stays 0x10, `id_instr`/`id_pc` unchanged, `fetch_count` frozen.
  - Release: next `id_pc` = 0x10, no duplicate and no skip.
- **Redirect:** at `pc` = 0x20, pulse `redirect` with `redirect_pc` = 0x100.
  - Same cycle: `flush` = 1.
  - Next cycle: `pc` = 0x100, `id_instr` = 0x00000013, `flush` = 1.
  - Cycle after: `id_pc` = 0x100, `flush` = 0.
- **Stall and redirect together:** `stall` = 1 and `redirect` = 1 with target 0x40 → next `pc` = 0x40 and IF/ID holds a bubble.
- **Misaligned target and wrap:**
  - Redirect to 0x103 → `pc` = 0x100, `misalign` = 1 and stays 1 until `Reset`.
  - Redirect to 0xFFFF_FFFC and advance → `pc` = 0x0, `id_pc_plus4` of 0xFFFF_FFFC = 0x0.
- **Asynchronous reset mid-stall:** assert `Reset` between clock edges while `stall` = 1 → all outputs take reset values immediately, without waiting for `clk`.

Source files
------------

// File: rtl/if_id_stage_if.sv
// Signal bundle between the fetch stage and its neighbours (hazard unit, EX
// redirect, instruction memory, ID decoder).
interface if_id_stage_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic        flush;
  logic        misalign;
  logic [31:0] fetch_count;

  // Surrounding pipeline / memory side.
  modport master (
    output stall, redirect, redirect_pc, imem_rdata,
    input  imem_addr, id_instr, id_pc, id_pc_plus4, id_valid, flush,
           misalign, fetch_count
  );

  // The fetch stage itself.
  modport slave (
    input  stall, redirect, redirect_pc, imem_rdata,
    output imem_addr, id_instr, id_pc, id_pc_plus4, id_valid, flush,
           misalign, fetch_count
  );
endinterface

// File: rtl/if_id_stage.sv
// RV32I instruction-fetch stage and IF/ID pipeline register with stall,
// redirect, sticky misalignment flag and a saturating fetch counter.
module if_id_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic           clk,
  input logic           Reset,
  if_id_stage_if.slave  bus
);

  logic [31:0] pc_reg,          pc_next;
  logic [31:0] id_instr_reg,    id_instr_next;
  logic [31:0] id_pc_reg,       id_pc_next;
  logic        id_valid_reg,    id_valid_next;
  logic        misalign_reg,    misalign_next;
  logic [31:0] fetch_count_reg, fetch_count_next;

  // Priority: redirect wins over stall, stall wins over advance.
  always_comb begin
    pc_next          = pc_reg;
    id_instr_next    = id_instr_reg;
    id_pc_next       = id_pc_reg;
    id_valid_next    = id_valid_reg;
    fetch_count_next = fetch_count_reg;
    misalign_next    = misalign_reg;

    if (bus.redirect) begin
      pc_next       = {bus.redirect_pc[31:2], 2'b00};
      id_instr_next = NOP_INSTR;
      id_pc_next    = 32'h0000_0000;
      id_valid_next = 1'b0;
      if (bus.redirect_pc[1:0] != 2'b00) begin
        misalign_next = 1'b1;
      end
    end else if (!bus.stall) begin
      pc_next       = pc_reg + 32'd4;
      id_instr_next = bus.imem_rdata;
      id_pc_next    = pc_reg;
      id_valid_next = 1'b1;
      if (fetch_count_reg != 32'hFFFF_FFFF) begin
        fetch_count_next = fetch_count_reg + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      pc_reg          <= PC_RESET;
      id_instr_reg    <= NOP_INSTR;
      id_pc_reg       <= 32'h0000_0000;
      id_valid_reg    <= 1'b0;
      misalign_reg    <= 1'b0;
      fetch_count_reg <= 32'h0000_0000;
    end else begin
      pc_reg          <= pc_next;
      id_instr_reg    <= id_instr_next;
      id_pc_reg       <= id_pc_next;
      id_valid_reg    <= id_valid_next;
      misalign_reg    <= misalign_next;
      fetch_count_reg <= fetch_count_next;
    end
  end

  assign bus.imem_addr   = pc_reg;
  assign bus.id_instr    = id_instr_reg;
  assign bus.id_pc       = id_pc_reg;
  assign bus.id_pc_plus4 = id_pc_reg + 32'd4;
  assign bus.id_valid    = id_valid_reg;
  // Redirect kills the wrong-path instruction in the same cycle.
  assign bus.flush       = bus.redirect | ~id_valid_reg;
  assign bus.misalign    = misalign_reg;
  assign bus.fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed testbench for if_id_stage: reset, run, stall, redirect, misalign,
// address wrap and asynchronous reset mid-stall.
module tb_if_id_stage;
  logic clk;
  logic Reset;
  int   n_checks;
  int   n_pass;

  if_id_stage_if bus();

  if_id_stage dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // addi x1, x0, (addr>>2): a distinct word per address.
  function automatic logic [31:0] instr_at(input logic [31:0] addr);
    return {addr[13:2], 5'd0, 3'd0, 5'd1, 7'h13};
  endfunction

  assign bus.imem_rdata = instr_at(bus.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %-14s got %08h exp %08h ok", tag, got, exp);
    end else begin
      $display("FAIL %-14s got %08h exp %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    Reset = 1'b1;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;

    // Reset held for two cycles
    step();
    step();
    check("rst_valid", {31'd0, bus.id_valid}, 32'd0);
    check("rst_flush", {31'd0, bus.flush}, 32'd1);
    check("rst_addr", bus.imem_addr, 32'h0);
    check("rst_instr", bus.id_instr, 32'h13);
    check("rst_count", bus.fetch_count, 32'd0);

    // Sequential run
    Reset = 1'b0;
    step();
    check("run1_addr", bus.imem_addr, 32'h4);
    check("run1_idpc", bus.id_pc, 32'h0);
    check("run1_instr", bus.id_instr, instr_at(32'h0));
    check("run1_flush", {31'd0, bus.flush}, 32'd0);
    step();
    check("run2_addr", bus.imem_addr, 32'h8);
    check("run2_idpc", bus.id_pc, 32'h4);
    step();
    check("run3_addr", bus.imem_addr, 32'hC);
    check("run3_count", bus.fetch_count, 32'd3);
    check("run3_plus4", bus.id_pc_plus4, 32'hC);
    step();
    check("pre_stall_pc", bus.imem_addr, 32'h10);

    // Two-cycle stall at pc 0x10
    bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall_addr", bus.imem_addr, 32'h10);
      check("stall_idpc", bus.id_pc, 32'hC);
      check("stall_count", bus.fetch_count, 32'd4);
    end
    bus.stall = 1'b0;
    step();
    check("unstall_idpc", bus.id_pc, 32'h10);
    check("unstall_instr", bus.id_instr, instr_at(32'h10));
    check("unstall_count", bus.fetch_count, 32'd5);
    step();
    step();
    step();
    check("pre_redir_pc", bus.imem_addr, 32'h20);

    // Redirect to 0x100
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h100;
    #1;
    check("redir_flush0", {31'd0, bus.flush}, 32'd1);
    step();
    bus.redirect = 1'b0;
    #1;
    check("redir_pc", bus.imem_addr, 32'h100);
    check("redir_instr", bus.id_instr, 32'h13);
    check("redir_flush1", {31'd0, bus.flush}, 32'd1);
    check("redir_count", bus.fetch_count, 32'd8);
    step();
    check("redir_idpc", bus.id_pc, 32'h100);
    check("redir_instr2", bus.id_instr, instr_at(32'h100));
    check("redir_flush2", {31'd0, bus.flush}, 32'd0);

    // Stall and redirect together
    bus.stall = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h40;
    step();
    bus.redirect = 1'b0;
    #1;
    check("sr_pc", bus.imem_addr, 32'h40);
    check("sr_valid", {31'd0, bus.id_valid}, 32'd0);
    // Stall holds the bubble
    step();
    check("sb_pc", bus.imem_addr, 32'h40);
    check("sb_flush", {31'd0, bus.flush}, 32'd1);
    bus.stall = 1'b0;
    check("pre_misalign", {31'd0, bus.misalign}, 32'd0);

    // Misaligned target
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h103;
    step();
    bus.redirect = 1'b0;
    #1;
    check("mis_pc", bus.imem_addr, 32'h100);
    check("mis_flag", {31'd0, bus.misalign}, 32'd1);
    step();
    check("mis_sticky", {31'd0, bus.misalign}, 32'd1);
    check("mis_idpc", bus.id_pc, 32'h100);

    // Wrap at top of address space
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    bus.redirect = 1'b0;
    #1;
    check("wrap_pc0", bus.imem_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_pc1", bus.imem_addr, 32'h0);
    check("wrap_idpc", bus.id_pc, 32'hFFFF_FFFC);
    check("wrap_plus4", bus.id_pc_plus4, 32'h0);
    check("wrap_count", bus.fetch_count, 32'd11);
    check("wrap_mis", {31'd0, bus.misalign}, 32'd1);

    // Asynchronous reset between edges while stalled
    bus.stall = 1'b1;
    #2;
    Reset = 1'b1;
    #1;
    check("arst_addr", bus.imem_addr, 32'h0);
    check("arst_valid", {31'd0, bus.id_valid}, 32'd0);
    check("arst_flush", {31'd0, bus.flush}, 32'd1);
    check("arst_mis", {31'd0, bus.misalign}, 32'd0);
    check("arst_count", bus.fetch_count, 32'd0);
    check("arst_instr", bus.id_instr, 32'h13);
    check("arst_idpc", bus.id_pc, 32'h0);
    #1;
    Reset = 1'b0;
    bus.stall = 1'b0;
    step();
    check("post_idpc", bus.id_pc, 32'h0);
    check("post_valid", {31'd0, bus.id_valid}, 32'd1);
    check("post_addr", bus.imem_addr, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
